// File: rtl/ddram_pkg.sv
// Shared widths, FSM state type and window decode for the DDRAM responder.
package ddram_pkg;

    localparam int DDR_AW  = 29;
    localparam int DDR_DW  = 64;
    localparam int DDR_BEW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBURST = 2'd1,
        RLAT   = 2'd2,
        RDATA  = 2'd3
    } ddr_state_t;

    // The responder owns one window selected by the top four address bits.
    function automatic logic window_hit(input logic [DDR_AW-1:0] addr,
                                        input logic [3:0]        base_hi);
        return addr[DDR_AW-1 -: 4] == base_hi;
    endfunction

endpackage

// File: rtl/ddram_bram.sv
// Byte-enabled simple dual-port RAM, 1-cycle registered read, write-first on address collision.
module ddram_bram
    import ddram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [DDR_DW-1:0]  wdata,
    input  logic [DDR_BEW-1:0] be,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [DDR_DW-1:0]  rdata
);

    logic [DDR_DW-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int k = 0; k < DDR_BEW; k++) begin
            if (we && be[k]) begin
                mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
            end
            // A lane written this cycle at the read address returns the new byte.
            if (we && be[k] && (waddr == raddr)) begin
                rdata[8*k +: 8] <= wdata[8*k +: 8];
            end else begin
                rdata[8*k +: 8] <= mem[raddr][8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/ddram_responder.sv
// Avalon-MM style memory end of the 64-bit DDRAM port, backed by a BRAM window.
module ddram_responder
    import ddram_pkg::*;
#(
    parameter int         ADDR_W  = 10,
    parameter logic [3:0] BASE_HI = 4'b0011,
    parameter int         RD_LAT  = 2
) (
    input  logic               DDRAM_CLK,
    input  logic               reset,
    output logic               DDRAM_BUSY,
    input  logic [7:0]         DDRAM_BURSTCNT,
    input  logic [DDR_AW-1:0]  DDRAM_ADDR,
    input  logic               DDRAM_RD,
    input  logic [DDR_DW-1:0]  DDRAM_DIN,
    input  logic [DDR_BEW-1:0] DDRAM_BE,
    input  logic               DDRAM_WE,
    output logic [DDR_DW-1:0]  DDRAM_DOUT,
    output logic               DDRAM_DOUT_READY,
    input  logic               stall_in,
    output logic               protocol_err,
    output ddr_state_t         state_dbg
);

    // Handshake: a command or write beat transfers on a rising edge where RD/WE is
    // high and DDRAM_BUSY is low; read beats are pushed with DOUT_READY and cannot stall.
    ddr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        beat_q, beat_d;
    logic [7:0]        remain_q, remain_d;
    logic [3:0]        lat_q, lat_d;
    logic              hit_q, hit_d;
    logic              err_q, err_d;

    logic              wr_en;
    logic [ADDR_W-1:0] waddr, raddr, addr_lo, beat_ext;
    logic [DDR_DW-1:0] rdata;
    logic [7:0]        burst_n;
    logic              hit_now;

    assign addr_lo  = DDRAM_ADDR[ADDR_W-1:0];
    assign beat_ext = ADDR_W'(beat_q);
    assign burst_n  = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
    assign hit_now  = window_hit(DDRAM_ADDR, BASE_HI);

    assign DDRAM_BUSY       = stall_in | (state_q == RLAT) | (state_q == RDATA);
    assign DDRAM_DOUT_READY = (state_q == RDATA);
    assign DDRAM_DOUT       = (state_q == RDATA && hit_q) ? rdata : '0;
    assign protocol_err     = err_q;
    assign state_dbg        = state_q;

    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            beat_q   <= '0;
            remain_q <= '0;
            lat_q    <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            beat_q   <= beat_d;
            remain_q <= remain_d;
            lat_q    <= lat_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        beat_d   = beat_q;
        remain_d = remain_q;
        lat_d    = lat_q;
        hit_d    = hit_q;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        waddr    = base_q + beat_ext;
        raddr    = addr_lo;

        case (state_q)
            IDLE: begin
                if (!DDRAM_BUSY && DDRAM_WE) begin
                    wr_en = hit_now;
                    waddr = addr_lo;
                    err_d = DDRAM_RD | ~hit_now;
                    if (burst_n > 8'd1) begin
                        base_d   = addr_lo;
                        beat_d   = 8'd1;
                        remain_d = burst_n - 8'd1;
                        hit_d    = hit_now;
                        state_d  = WBURST;
                    end
                end else if (!DDRAM_BUSY && DDRAM_RD) begin
                    base_d   = addr_lo;
                    beat_d   = 8'd0;
                    remain_d = burst_n;
                    hit_d    = hit_now;
                    err_d    = ~hit_now;
                    lat_d    = 4'(RD_LAT - 1);
                    state_d  = (RD_LAT <= 1) ? RDATA : RLAT;
                end
            end
            WBURST: begin
                if (!DDRAM_BUSY) begin
                    err_d = DDRAM_RD;
                    if (DDRAM_WE) begin
                        wr_en    = hit_q;
                        beat_d   = beat_q + 8'd1;
                        remain_d = remain_q - 8'd1;
                        if (remain_q == 8'd1) begin
                            beat_d  = 8'd0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            RLAT: begin
                // Keep addressing the first beat so it is registered on entry to RDATA.
                raddr = base_q;
                if (lat_q <= 4'd1) begin
                    state_d = RDATA;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RDATA: begin
                raddr    = base_q + beat_ext + ADDR_W'(1);
                beat_d   = beat_q + 8'd1;
                remain_d = remain_q - 8'd1;
                if (remain_q == 8'd1) begin
                    beat_d  = 8'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    ddram_bram #(.ADDR_W(ADDR_W)) u_bram (
        .clk   (DDRAM_CLK),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (DDRAM_DIN),
        .be    (DDRAM_BE),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ddram_responder.sv
// Directed bench for ddram_responder: burst writes/reads, wrap, stall, protocol errors, reset abort.
module tb_ddram_responder;
    import ddram_pkg::*;

    localparam int          RD_LAT = 2;
    localparam logic [28:0] WIN    = 29'h0600_0000;
    localparam logic [28:0] MISS   = 29'h0400_0000;

    logic        DDRAM_CLK;
    logic        reset;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        stall_in;
    logic        protocol_err;
    ddr_state_t  state_dbg;

    int n_total = 0;
    int n_bad   = 0;
    logic [63:0] exp_q[$];

    ddram_responder #(.ADDR_W(10), .BASE_HI(4'b0011), .RD_LAT(RD_LAT)) dut (
        .DDRAM_CLK        (DDRAM_CLK),
        .reset            (reset),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE),
        .DDRAM_WE         (DDRAM_WE),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
        .stall_in         (stall_in),
        .protocol_err     (protocol_err),
        .state_dbg        (state_dbg)
    );

    // Clock and watchdog
    initial begin
        DDRAM_CLK = 1'b0;
        forever #5 DDRAM_CLK = ~DDRAM_CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [63:0] pat(input int i);
        return {16'hA000 + 16'(i), 16'hB000 + 16'(i), 16'hC000 + 16'(i), 16'hD000 + 16'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change just after the falling edge, outputs are checked 1ns later.
    task automatic tick();
        @(negedge DDRAM_CLK);
    endtask

    task automatic drive(input logic rd, input logic we, input logic [28:0] addr,
                         input logic [7:0] cnt, input logic [63:0] din, input logic [7:0] be);
        DDRAM_RD       = rd;
        DDRAM_WE       = we;
        DDRAM_ADDR     = addr;
        DDRAM_BURSTCNT = cnt;
        DDRAM_DIN      = din;
        DDRAM_BE       = be;
    endtask

    task automatic wr_single(input logic [28:0] addr, input logic [63:0] din,
                             input logic [7:0] be, input int stall_cycles);
        tick();
        drive(1'b0, 1'b1, addr, 8'd1, din, be);
        for (int i = 0; i < stall_cycles; i++) begin
            stall_in = 1'b1;
            #1;
            check("wr_stall_busy", 64'(DDRAM_BUSY), 64'd1);
            check("wr_stall_state", 64'(state_dbg), 64'(IDLE));
            tick();
        end
        stall_in = 1'b0;
        #1;
        check("wr_accept_busy", 64'(DDRAM_BUSY), 64'd0);
    endtask

    // Issues one read and checks every following cycle against the expected queue.
    task automatic rd_burst(input logic [28:0] addr, input logic [7:0] cnt,
                            input int stall_cycles, input logic exp_err);
        int n;
        logic [63:0] exp_v;
        n = (cnt == 8'd0) ? 1 : int'(cnt);
        tick();
        drive(1'b1, 1'b0, addr, cnt, 64'd0, 8'd0);
        for (int i = 0; i < stall_cycles; i++) begin
            stall_in = 1'b1;
            #1;
            check("rd_stall_busy", 64'(DDRAM_BUSY), 64'd1);
            check("rd_stall_ready", 64'(DDRAM_DOUT_READY), 64'd0);
            check("rd_stall_state", 64'(state_dbg), 64'(IDLE));
            tick();
        end
        stall_in = 1'b0;
        #1;
        check("rd_accept_busy", 64'(DDRAM_BUSY), 64'd0);
        tick();
        drive(1'b0, 1'b0, 29'd0, 8'd0, 64'd0, 8'd0);
        for (int c = 1; c <= RD_LAT + n; c++) begin
            #1;
            if (c == 1) check("rd_err", 64'(protocol_err), 64'(exp_err));
            if (c < RD_LAT) begin
                check("rd_lat_ready", 64'(DDRAM_DOUT_READY), 64'd0);
                check("rd_lat_busy", 64'(DDRAM_BUSY), 64'd1);
                check("rd_lat_state", 64'(state_dbg), 64'(RLAT));
            end else if (c < RD_LAT + n) begin
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                check("rd_beat_ready", 64'(DDRAM_DOUT_READY), 64'd1);
                check("rd_beat_data", DDRAM_DOUT, exp_v);
                check("rd_beat_busy", 64'(DDRAM_BUSY), 64'd1);
            end else begin
                check("rd_end_ready", 64'(DDRAM_DOUT_READY), 64'd0);
                check("rd_end_busy", 64'(DDRAM_BUSY), 64'd0);
                check("rd_end_state", 64'(state_dbg), 64'(IDLE));
            end
            if (c < RD_LAT + n) tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        stall_in = 1'b0;
        drive(1'b0, 1'b0, 29'd0, 8'd0, 64'd0, 8'd0);
        repeat (3) tick();
        #1;
        check("rst_busy", 64'(DDRAM_BUSY), 64'd0);
        check("rst_dout", DDRAM_DOUT, 64'd0);
        check("rst_ready", 64'(DDRAM_DOUT_READY), 64'd0);
        check("rst_err", 64'(protocol_err), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        tick();
        reset = 1'b0;

        // Known contents
        for (int i = 0; i < 4; i++) wr_single(WIN + 29'(i), pat(i), 8'hFF, 0);
        wr_single(WIN + 29'h10, pat(16'h10), 8'hFF, 0);
        wr_single(WIN + 29'h11, pat(16'h11), 8'hFF, 0);

        // Partial byte write, read back immediately after
        wr_single(WIN + 29'h10, {4{16'hBEEF}}, 8'h0C, 0);
        exp_q.push_back(64'hA010_B010_BEEF_D010);
        exp_q.push_back(64'hA011_B011_C011_D011);
        rd_burst(WIN + 29'h10, 8'd2, 0, 1'b0);

        // Burst-4 latency and data
        for (int i = 0; i < 4; i++) exp_q.push_back(pat(i));
        rd_burst(WIN, 8'd4, 0, 1'b0);

        // Write burst of 3 with gaps across the top of the window
        tick(); drive(1'b0, 1'b1, WIN + 29'h3FF, 8'd3, 64'h1111_0000_0000_03FF, 8'hFF);
        tick(); drive(1'b0, 1'b0, 29'd0, 8'd0, 64'd0, 8'd0);
        #1 check("wrap_gap_state", 64'(state_dbg), 64'(WBURST));
        tick(); drive(1'b0, 1'b1, 29'd0, 8'd3, 64'h2222_0000_0000_0000, 8'hFF);
        tick(); drive(1'b0, 1'b0, 29'd0, 8'd0, 64'd0, 8'd0);
        tick(); drive(1'b0, 1'b1, 29'd0, 8'd3, 64'h3333_0000_0000_0001, 8'hFF);
        tick(); drive(1'b0, 1'b0, 29'd0, 8'd0, 64'd0, 8'd0);
        #1 check("wrap_end_state", 64'(state_dbg), 64'(IDLE));
        exp_q.push_back(64'h1111_0000_0000_03FF);
        exp_q.push_back(64'h2222_0000_0000_0000);
        exp_q.push_back(64'h3333_0000_0000_0001);
        rd_burst(WIN + 29'h3FF, 8'd3, 0, 1'b0);
        exp_q.push_back(pat(2));
        rd_burst(WIN + 29'h2, 8'd0, 0, 1'b0);
        exp_q.push_back(64'h2222_0000_0000_0000);
        rd_burst(WIN + 29'h400, 8'd1, 0, 1'b0);

        // Stall holds off both a write and a read
        wr_single(WIN + 29'h30, 64'h5555_6666_7777_8888, 8'hFF, 3);
        exp_q.push_back(64'h5555_6666_7777_8888);
        rd_burst(WIN + 29'h30, 8'd1, 3, 1'b0);

        // RD and WE together in IDLE: write wins
        tick(); drive(1'b1, 1'b1, WIN + 29'h20, 8'd1, 64'h0123_4567_89AB_CDEF, 8'hFF);
        #1 check("both_busy", 64'(DDRAM_BUSY), 64'd0);
        tick(); drive(1'b0, 1'b0, 29'd0, 8'd0, 64'd0, 8'd0);
        #1 check("both_err", 64'(protocol_err), 64'd1);
        check("both_state", 64'(state_dbg), 64'(IDLE));
        check("both_ready", 64'(DDRAM_DOUT_READY), 64'd0);
        tick();
        #1 check("both_err_once", 64'(protocol_err), 64'd0);
        check("both_no_beat", 64'(DDRAM_DOUT_READY), 64'd0);
        exp_q.push_back(64'h0123_4567_89AB_CDEF);
        rd_burst(WIN + 29'h20, 8'd1, 0, 1'b0);

        // RD during a write burst is ignored
        tick(); drive(1'b0, 1'b1, WIN + 29'h21, 8'd2, 64'hAAAA_0000_0000_0021, 8'hFF);
        tick(); drive(1'b1, 1'b0, WIN + 29'h40, 8'd1, 64'd0, 8'd0);
        #1 check("wbrd_state", 64'(state_dbg), 64'(WBURST));
        tick(); drive(1'b0, 1'b1, 29'd0, 8'd2, 64'hBBBB_0000_0000_0022, 8'hFF);
        #1 check("wbrd_err", 64'(protocol_err), 64'd1);
        check("wbrd_state2", 64'(state_dbg), 64'(WBURST));
        tick(); drive(1'b0, 1'b0, 29'd0, 8'd0, 64'd0, 8'd0);
        #1 check("wbrd_err_once", 64'(protocol_err), 64'd0);
        check("wbrd_end_state", 64'(state_dbg), 64'(IDLE));
        check("wbrd_no_beat", 64'(DDRAM_DOUT_READY), 64'd0);
        exp_q.push_back(64'hAAAA_0000_0000_0021);
        exp_q.push_back(64'hBBBB_0000_0000_0022);
        rd_burst(WIN + 29'h21, 8'd2, 0, 1'b0);

        // Outside the window: write discarded, read returns zeros
        tick(); drive(1'b0, 1'b1, MISS + 29'h10, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        tick(); drive(1'b0, 1'b0, 29'd0, 8'd0, 64'd0, 8'd0);
        #1 check("miss_wr_err", 64'(protocol_err), 64'd1);
        exp_q.push_back(64'hA010_B010_BEEF_D010);
        rd_burst(WIN + 29'h10, 8'd1, 0, 1'b0);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        rd_burst(MISS, 8'd2, 0, 1'b1);

        // Reset during beat 2 of a 4-beat read
        tick(); drive(1'b1, 1'b0, WIN + 29'h10, 8'd4, 64'd0, 8'd0);
        tick(); drive(1'b0, 1'b0, 29'd0, 8'd0, 64'd0, 8'd0);
        tick();
        #1 check("rst_b0_data", DDRAM_DOUT, 64'hA010_B010_BEEF_D010);
        tick();
        #1 check("rst_b1_data", DDRAM_DOUT, 64'hA011_B011_C011_D011);
        tick();
        #1 check("rst_b2_ready", 64'(DDRAM_DOUT_READY), 64'd1);
        reset = 1'b1;
        #1 check("abort_ready", 64'(DDRAM_DOUT_READY), 64'd0);
        check("abort_busy", 64'(DDRAM_BUSY), 64'd0);
        check("abort_state", 64'(state_dbg), 64'(IDLE));
        check("abort_dout", DDRAM_DOUT, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        #1 check("abort_no_beat", 64'(DDRAM_DOUT_READY), 64'd0);
        exp_q.push_back(pat(2));
        exp_q.push_back(pat(3));
        rd_burst(WIN + 29'h2, 8'd2, 0, 1'b0);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
